// File: rtl/fetch_if.sv
// fetch_if: bundles the fetch-stage control, ROM and decode-side signals.
// The slave modport is taken by fetch_ctrl; the master modport is the
// environment side (execute redirect, stall source, ROM and decode).
interface fetch_if;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        stall_i;
    logic [31:0] rom_inst_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        fetch_err_o;

    modport slave (
        input  jump_en_i, jump_addr_i, stall_i, rom_inst_i,
        output pc_o, inst_o, inst_pc_o, inst_valid_o, fetch_err_o
    );

    modport master (
        output jump_en_i, jump_addr_i, stall_i, rom_inst_i,
        input  pc_o, inst_o, inst_pc_o, inst_valid_o, fetch_err_o
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencing and instruction hand-off to decode
// for a ROM with one cycle of registered read latency.
// Stage p0 is the address presented to the ROM, stage p1 is the word coming
// back. A hold register keeps the word alive while decode is stalled, and a
// redirect flushes the wrong-path word already in flight.
// Optional build macro FETCH_MISALIGN_CHK_EN enables a sticky flag for
// redirects whose target is not word aligned.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.slave bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] pc_p0;
    logic [31:0] inst_pc_p1;
    logic        vld_p1;
    logic        stall_q;
    logic [31:0] hold_q;
    logic [31:0] inst_sel;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Stage p0: next fetch address (redirect, then hold, then sequential wrap).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0 <= RESET_PC;
        end else if (bus.jump_en_i) begin
            pc_p0 <= align_word(bus.jump_addr_i);
        end else if (!bus.stall_i) begin
            pc_p0 <= pc_p0 + 32'd4;
        end
    end

    // Stage p1: address and validity of the word returning from the ROM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_pc_p1 <= RESET_PC;
            vld_p1     <= 1'b0;
        end else if (bus.jump_en_i) begin
            inst_pc_p1 <= pc_p0;
            vld_p1     <= 1'b0;
        end else if (!bus.stall_i) begin
            inst_pc_p1 <= pc_p0;
            vld_p1     <= 1'b1;
        end
    end

    // Track stall history and capture the ROM word on the first stalled edge,
    // since the ROM moves on to the next address while decode is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
            hold_q  <= 32'h0;
        end else begin
            stall_q <= bus.jump_en_i ? 1'b0 : bus.stall_i;
            if (bus.stall_i && !bus.jump_en_i && !stall_q) begin
                hold_q <= bus.rom_inst_i;
            end
        end
    end

    // Decode sees NOP when invalid, the captured word while stalled, else the ROM.
    always_comb begin
        inst_sel = bus.rom_inst_i;
        if (!vld_p1) begin
            inst_sel = NOP;
        end else if (stall_q) begin
            inst_sel = hold_q;
        end
    end

    assign bus.pc_o         = pc_p0;
    assign bus.inst_pc_o    = inst_pc_p1;
    assign bus.inst_valid_o = vld_p1;
    assign bus.inst_o       = inst_sel;

`ifdef FETCH_MISALIGN_CHK_EN
    logic err_q;

    // Sticky flag: any redirect with nonzero low address bits, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (bus.jump_en_i && (bus.jump_addr_i[1:0] != 2'b00)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.fetch_err_o = err_q;
`else
    logic unused_addr_lo;
    assign unused_addr_lo  = ^bus.jump_addr_i[1:0];
    assign bus.fetch_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: drives fetch_ctrl against a registered ROM model holding
// word[n] = n+1 and scoreboards the delivered instruction stream.
module tb_fetch_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [31:0] exp_q[$];
    logic        exp_err;

    fetch_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return (addr >> 2) + 32'd1;
    endfunction

    // ROM model: one cycle of registered read latency on pc_o.
    always @(posedge clk) bus.rom_inst_i <= rom_word(bus.pc_o);

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Delivery monitor: a word is consumed by decode when valid and not stalled.
    always @(negedge clk) begin
        if (rst_n && bus.inst_valid_o && !bus.stall_i) begin
            if (exp_q.size() == 0) begin
                chk_eq("sb_pending", exp_q.size(), 1);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk_eq("sb_pc", bus.inst_pc_o, e);
                chk_eq("sb_inst", bus.inst_o, rom_word(e));
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
`ifdef FETCH_MISALIGN_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n           = 1'b0;
        bus.jump_en_i   = 1'b0;
        bus.jump_addr_i = 32'h0;
        bus.stall_i     = 1'b0;
        repeat (3) tick();

        chk_eq("rst_pc", bus.pc_o, 32'h0);
        chk_eq("rst_inst_pc", bus.inst_pc_o, 32'h0);
        chk_eq("rst_valid", bus.inst_valid_o, 1'b0);
        chk_eq("rst_inst_nop", bus.inst_o, 32'h13);
        chk_eq("rst_err", bus.fetch_err_o, 1'b0);

        // Straight-line fetch, then a 3-cycle stall at inst_pc 8.
        foreach (exp_q[i]) ;
        exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);  exp_q.push_back(32'h10);
        rst_n = 1'b1;
        tick();
        chk_eq("c1_valid", bus.inst_valid_o, 1'b1);
        chk_eq("c1_inst_pc", bus.inst_pc_o, 32'h0);
        chk_eq("c1_inst", bus.inst_o, 32'h1);
        chk_eq("c1_pc", bus.pc_o, 32'h4);
        tick();
        chk_eq("c2_inst_pc", bus.inst_pc_o, 32'h4);
        chk_eq("c2_inst", bus.inst_o, 32'h2);
        tick();
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("stall_inst", bus.inst_o, 32'h3);
            chk_eq("stall_pc", bus.pc_o, 32'hC);
            chk_eq("stall_inst_pc", bus.inst_pc_o, 32'h8);
        end
        bus.stall_i = 1'b0;
        tick();
        chk_eq("rel_inst_pc", bus.inst_pc_o, 32'hC);
        chk_eq("rel_inst", bus.inst_o, 32'h4);
        tick();
        chk_eq("rel2_inst_pc", bus.inst_pc_o, 32'h10);

        // Redirect to 0x40 from inst_pc 0x10.
        exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h80);
        bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h40;
        tick();
        bus.jump_en_i = 1'b0;
        chk_eq("jmp_valid", bus.inst_valid_o, 1'b0);
        chk_eq("jmp_nop", bus.inst_o, 32'h13);
        chk_eq("jmp_pc", bus.pc_o, 32'h40);
        tick();
        chk_eq("jmp_tgt_pc", bus.inst_pc_o, 32'h40);
        chk_eq("jmp_tgt_valid", bus.inst_valid_o, 1'b1);
        chk_eq("jmp_tgt_inst", bus.inst_o, 32'h11);
        tick();

        // Redirect while stalled: word at 0x48 is dropped, target wins.
        tick();
        bus.stall_i = 1'b1;
        tick();
        bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h80;
        tick();
        bus.jump_en_i = 1'b0; bus.stall_i = 1'b0;
        chk_eq("js_valid", bus.inst_valid_o, 1'b0);
        chk_eq("js_nop", bus.inst_o, 32'h13);
        tick();
        chk_eq("js_tgt_pc", bus.inst_pc_o, 32'h80);
        chk_eq("js_tgt_inst", bus.inst_o, 32'h21);

        // Back-to-back redirects: only the second target is delivered.
        exp_q.push_back(32'h100);
        bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'hC0;
        tick();
        chk_eq("bb1_pc", bus.pc_o, 32'hC0);
        bus.jump_addr_i = 32'h100;
        tick();
        bus.jump_en_i = 1'b0;
        chk_eq("bb2_valid", bus.inst_valid_o, 1'b0);
        chk_eq("bb2_pc", bus.pc_o, 32'h100);
        tick();
        chk_eq("bb_tgt_pc", bus.inst_pc_o, 32'h100);

        // Sequential wrap at the top of the address space.
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'hFFFF_FFFC;
        tick();
        bus.jump_en_i = 1'b0;
        tick();
        chk_eq("wrap_pc", bus.pc_o, 32'h0);
        tick();
        tick();

        // Misaligned redirect: aligned target, sticky flag depends on build.
        exp_q.push_back(32'h40);
        bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h42;
        tick();
        bus.jump_en_i = 1'b0;
        chk_eq("mis_pc", bus.pc_o, 32'h40);
        chk_eq("mis_err", bus.fetch_err_o, exp_err);
        tick();
        bus.jump_en_i = 1'b1; bus.jump_addr_i = 32'h10;
        tick();
        bus.jump_en_i = 1'b0;
        chk_eq("mis_err_sticky", bus.fetch_err_o, exp_err);
        tick();
        chk_eq("al_inst_pc", bus.inst_pc_o, 32'h10);
        chk_eq("sb_drain", exp_q.size(), 0);

        // Reset asserted mid-stall discards hold/stall state.
        bus.stall_i = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("mrst_pc", bus.pc_o, 32'h0);
        chk_eq("mrst_inst_pc", bus.inst_pc_o, 32'h0);
        chk_eq("mrst_valid", bus.inst_valid_o, 1'b0);
        chk_eq("mrst_nop", bus.inst_o, 32'h13);
        chk_eq("mrst_err", bus.fetch_err_o, 1'b0);
        bus.stall_i = 1'b0;
        exp_q.delete();
        tick();
        tick();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        rst_n = 1'b1;
        tick();
        chk_eq("post_valid", bus.inst_valid_o, 1'b1);
        chk_eq("post_inst", bus.inst_o, 32'h1);
        tick();
        chk_eq("post_inst2", bus.inst_o, 32'h2);
        @(posedge clk);
        #1;
        chk_eq("sb_drain2", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
